// File: rtl/vga_pattern_gen_pkg.sv
// Shared encodings for the VGA test-pattern generator: mode codes, 3-bit colours, default timing.
package vga_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_VBAR   = 2'd0,
    MODE_HBAR   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] RED     = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] YELLOW  = 3'd3;
  localparam logic [2:0] BLUE    = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] CYAN    = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_NBARS    = 8;
  localparam int DEF_CW       = 3;
  localparam int DEF_CNT_W    = 10;

  // Bar width in pixels/lines; the remainder is absorbed by the last bar.
  function automatic int bar_len(input int len, input int nbars);
    return len / nbars;
  endfunction

endpackage

// File: rtl/vga_bar_index.sv
// Combinational coordinate -> bar index; saturates at NBARS-1 so remainder and out-of-range
// coordinates fall into the last bar.
module vga_bar_index
  import vga_pattern_gen_pkg::*;
#(
  parameter int LEN   = 800,
  parameter int NBARS = 8,
  parameter int CNT_W = 10
) (
  input  logic [CNT_W-1:0]         coord_i,
  output logic [$clog2(NBARS)-1:0] idx_o
);

  localparam int BAR = bar_len(LEN, NBARS);

  int cnt;

  always_comb begin
    cnt = 0;
    for (int k = 1; k < NBARS; k++) begin
      if (32'(coord_i) >= 32'(k * BAR)) cnt = cnt + 1;
    end
    idx_o = $clog2(NBARS)'(cnt);
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Registered VGA test-pattern generator, 2-cycle latency from hcnt/vcnt/nblank to vga_d.
// Mode is latched at frame start so a picture never mixes two patterns.
module vga_pattern_gen
  import vga_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int NBARS       = DEF_NBARS,
  parameter int CW          = DEF_CW,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SCROLL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nblank,
  input  logic [CNT_W-1:0] hcnt,
  input  logic [CNT_W-1:0] vcnt,
  input  logic [1:0]       mode,
  input  logic             scroll_en,
  output logic [CW-1:0]    vga_d,
  output logic             frame_tick
);

  localparam int XW    = CNT_W + 1;
  localparam int IDX_W = $clog2(NBARS);

  mode_e            mode_q, mode_pix;
  logic [CNT_W-1:0] offset_q, offset_d;
  logic             fs;
  logic [XW-1:0]    x_sum, off_sum, xeff_d;

  // S1
  logic [XW-1:0]    xeff_q;
  logic [CNT_W-1:0] y_q;
  logic             nblank_d1_q, fs_d1_q;
  mode_e            mode_d1_q;

  // S2
  logic [CW-1:0]    vga_d_q, col;
  logic             frame_tick_q;
  logic [IDX_W-1:0] hidx, vidx;

  assign fs = nblank && (hcnt == '0) && (vcnt == '0);

  // The fs pixel already uses the newly sampled mode.
  assign mode_pix = fs ? mode_e'(mode) : mode_q;

  // Offset advance is gated by the mode of the frame that is ending.
  always_comb begin
    offset_d = offset_q;
    off_sum  = {1'b0, offset_q} + XW'(SCROLL_STEP);
    if (off_sum >= XW'(H_ACTIVE)) off_sum = off_sum - XW'(H_ACTIVE);
    if (fs && (mode_q == MODE_SCROLL) && scroll_en) offset_d = off_sum[CNT_W-1:0];
  end

  always_comb begin
    x_sum  = {1'b0, hcnt} + {1'b0, offset_q};
    xeff_d = {1'b0, hcnt};
    if (mode_pix == MODE_SCROLL)
      xeff_d = (x_sum >= XW'(H_ACTIVE)) ? x_sum - XW'(H_ACTIVE) : x_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_VBAR;
      offset_q    <= '0;
      xeff_q      <= '0;
      y_q         <= '0;
      nblank_d1_q <= 1'b0;
      fs_d1_q     <= 1'b0;
      mode_d1_q   <= MODE_VBAR;
    end else begin
      if (fs) mode_q <= mode_e'(mode);
      offset_q    <= offset_d;
      xeff_q      <= xeff_d;
      y_q         <= vcnt;
      nblank_d1_q <= nblank;
      fs_d1_q     <= fs;
      mode_d1_q   <= mode_pix;
    end
  end

  vga_bar_index #(.LEN(H_ACTIVE), .NBARS(NBARS), .CNT_W(XW)) u_hidx (
    .coord_i (xeff_q),
    .idx_o   (hidx)
  );

  vga_bar_index #(.LEN(V_ACTIVE), .NBARS(NBARS), .CNT_W(CNT_W)) u_vidx (
    .coord_i (y_q),
    .idx_o   (vidx)
  );

  always_comb begin
    col = CW'(BLACK);
    case (mode_d1_q)
      MODE_VBAR, MODE_SCROLL: col = CW'(32'(hidx) + 32'd1);
      MODE_HBAR:              col = CW'(32'(vidx) + 32'd1);
      MODE_CHECK:             col = (hidx[0] ^ vidx[0]) ? '1 : '0;
      default:                col = CW'(BLACK);
    endcase
    if (!nblank_d1_q) col = CW'(BLACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_d_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      vga_d_q      <= col;
      frame_tick_q <= fs_d1_q;
    end
  end

  assign vga_d      = vga_d_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised + directed bench for vga_pattern_gen against a division-based pixel model.
module tb_vga_pattern_gen;

  localparam int H  = 800;
  localparam int V  = 600;
  localparam int NB = 8;
  localparam int ST = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nblank = 1'b0;
  logic [9:0] hcnt = '0;
  logic [9:0] vcnt = '0;
  logic [1:0] mode = '0;
  logic       scroll_en = 1'b0;
  logic [2:0] vga_d;
  logic       frame_tick;

  vga_pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nblank     (nblank),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .mode       (mode),
    .scroll_en  (scroll_en),
    .vga_d      (vga_d),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    col;
    int    tick;
    int    hard;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_mode = 0;
  int   m_off  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bidx(input int c, input int len);
    int i;
    i = c / (len / NB);
    return (i > NB - 1) ? NB - 1 : i;
  endfunction

  task automatic model_reset();
    exp_t z;
    m_mode = 0;
    m_off  = 0;
    q.delete();
    z.col = 0; z.tick = 0; z.hard = -1; z.tag = "";
    q.push_back(z);
  endtask

  task automatic cyc(input int nb, input int h, input int v, input int m, input int se,
                     input int hard = -1, input string tag = "");
    exp_t e, o;
    int   fs, mp, x, hi, vi;
    nblank = nb[0]; hcnt = h[9:0]; vcnt = v[9:0]; mode = m[1:0]; scroll_en = se[0];
    fs = (nb != 0 && h == 0 && v == 0) ? 1 : 0;
    mp = fs ? m : m_mode;
    x  = h;
    if (mp == 3) begin
      x = h + m_off;
      if (x >= H) x = x - H;
    end
    hi = bidx(x, H);
    vi = bidx(v, V);
    case (mp)
      0, 3:    e.col = (hi + 1) % 8;
      1:       e.col = (vi + 1) % 8;
      default: e.col = ((hi ^ vi) & 1) ? 7 : 0;
    endcase
    if (nb == 0) e.col = 0;
    e.tick = fs;
    e.hard = hard;
    e.tag  = tag;
    if (fs) begin
      if (m_mode == 3 && se != 0) m_off = (m_off + ST) % H;
      m_mode = m;
    end
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() >= 2) begin
      o = q.pop_front();
      chk("pix", int'(vga_d), o.col);
      chk("tick", int'(frame_tick), o.tick);
      if (o.hard >= 0) chk(o.tag, int'(vga_d), o.hard);
    end
  endtask

  int sv_fr[3] = '{1, 1, 2};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vga", int'(vga_d), 0);
    chk("rst_tick", int'(frame_tick), 0);
    rst_n = 1'b1;
    model_reset();

    // vertical bars across one full line
    for (int h = 0; h < H; h++)
      cyc(1, h, 0, 0, 0, (h < 700) ? h / 100 + 1 : 0, "m0_sweep");

    // horizontal bars
    cyc(1, 0, 0, 1, 0, 1, "m1_fs");
    cyc(1, 5, 74, 1, 0, 1, "m1_v74");
    cyc(1, 5, 75, 1, 0, 2, "m1_v75");
    cyc(1, 5, 599, 1, 0, 0, "m1_v599");

    for (int i = 0; i < 20; i++)
      cyc(0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3), 0, 0, "blank");

    // checkerboard
    cyc(1, 0, 0, 2, 0, 0, "ck_0_0");
    cyc(1, 100, 0, 2, 0, 7, "ck_100_0");
    cyc(1, 100, 75, 2, 0, 0, "ck_100_75");

    // scroll: offsets 0,1,2 over three frames
    for (int f = 0; f < 3; f++) begin
      cyc(1, 0, 0, 3, 1);
      cyc(1, 98, 0, 3, 1, sv_fr[f], "scroll_h98");
      cyc(1, 799, 0, 3, 1);
      cyc(1, 50, 1, 3, 1);
    end
    chk("pre_rst_nonzero", int'(vga_d != 3'd0), 1);

    // reset mid-line
    rst_n = 1'b0;
    #1;
    chk("midrst_vga", int'(vga_d), 0);
    chk("midrst_tick", int'(frame_tick), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cyc(1, 0, 0, 3, 1);
    cyc(1, 98, 0, 3, 1, 1, "post_rst_off0");
    cyc(1, 0, 0, 3, 1);
    cyc(1, 98, 0, 3, 1, 1, "post_rst_off0b");

    // mode change mid-frame only takes effect at next frame start
    cyc(1, 0, 0, 0, 0);
    for (int h = 380; h <= 420; h++)
      cyc(1, h, 80, (h >= 400) ? 1 : 0, 0, (h < 400) ? 4 : 5, "midchg");
    cyc(1, 0, 0, 1, 0, 1, "chg_fs");
    cyc(1, 450, 80, 1, 0, 2, "chg_m1");

    for (int i = 0; i < 3000; i++) begin
      int nb, h, v;
      nb = ($urandom_range(0, 9) != 0) ? 1 : 0;
      if ($urandom_range(0, 39) == 0) begin
        h = 0; v = 0;
      end else begin
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 1023);
      end
      cyc(nb, h, v, $urandom_range(0, 3), $urandom_range(0, 1));
    end
    cyc(0, 5, 5, 0, 0);
    cyc(0, 5, 5, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
